multicycle_ctrl_fsm: RTL

//  Main control FSM for the multicycle MIPS datapath; successor to the fixed-latency controller.

---
 rtl/multicycle_ctrl_fsm_pkg.sv | 94 +++++++++
 rtl/multicycle_ctrl_fsm_if.sv | 10 +
 rtl/multicycle_ctrl_fsm_wait_timer.sv | 27 ++
 rtl/multicycle_ctrl_fsm.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/multicycle_ctrl_fsm_pkg.sv
// mc_ctrl_pkg: opcodes, state encoding, datapath control enums and the
// per-state control decode shared by the multicycle MIPS controller.
package mc_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWR, S_MEMWB, S_EXEC, S_ALUWB,
    S_BEQ, S_BNE, S_IMMEX, S_IMMWB, S_JUMP, S_JAL, S_HALT
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000, ALU_SUB = 3'b001, ALU_FUNCT = 3'b010,
    ALU_AND = 3'b011, ALU_OR = 3'b100
  } alu_op_t;

  typedef enum logic [1:0] {PC_ALU = 2'b00, PC_ALUOUT = 2'b01, PC_JUMP = 2'b10} pc_src_t;
  typedef enum logic [1:0] {SRCB_B = 2'b00, SRCB_FOUR = 2'b01, SRCB_IMM = 2'b10, SRCB_IMM_SH2 = 2'b11} src_b_t;
  typedef enum logic [1:0] {DST_RT = 2'b00, DST_RD = 2'b01, DST_R31 = 2'b10} reg_dst_t;
  typedef enum logic [1:0] {WB_ALUOUT = 2'b00, WB_DATA = 2'b01, WB_PC = 2'b10} wb_sel_t;

  // Moore part of the control word; fetch-time enables are gated by mem_ready in the top.
  typedef struct packed {
    logic     mem_req;
    logic     mem_write;
    logic     i_or_d;
    logic     pc_write;
    logic     branch;
    logic     branch_ne;
    pc_src_t  pc_src;
    logic     alu_src_a;
    src_b_t   alu_src_b;
    alu_op_t  alu_op;
    logic     reg_write;
    reg_dst_t reg_dst;
    wb_sel_t  wb_sel;
    logic     halted;
  } ctrl_t;

  // Control word for a state; op only matters for IMMEX (selects the ALU op).
  function automatic ctrl_t ctrl_of(state_t s, logic [5:0] op);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH:  begin c.mem_req = 1'b1; c.alu_src_b = SRCB_FOUR; end
      S_DECODE: c.alu_src_b = SRCB_IMM_SH2;
      S_MEMADR: begin c.alu_src_a = 1'b1; c.alu_src_b = SRCB_IMM; end
      S_MEMRD:  begin c.mem_req = 1'b1; c.i_or_d = 1'b1; end
      S_MEMWR:  begin c.mem_req = 1'b1; c.mem_write = 1'b1; c.i_or_d = 1'b1; end
      S_MEMWB:  begin c.reg_write = 1'b1; c.reg_dst = DST_RT; c.wb_sel = WB_DATA; end
      S_EXEC:   begin c.alu_src_a = 1'b1; c.alu_src_b = SRCB_B; c.alu_op = ALU_FUNCT; end
      S_ALUWB:  begin c.reg_write = 1'b1; c.reg_dst = DST_RD; c.wb_sel = WB_ALUOUT; end
      S_BEQ, S_BNE: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_B;
        c.alu_op    = ALU_SUB;
        c.pc_src    = PC_ALUOUT;
        c.branch    = (s == S_BEQ);
        c.branch_ne = (s == S_BNE);
      end
      S_IMMEX: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        case (op)
          OP_ANDI: c.alu_op = ALU_AND;
          OP_ORI:  c.alu_op = ALU_OR;
          default: c.alu_op = ALU_ADD;
        endcase
      end
      S_IMMWB:  begin c.reg_write = 1'b1; c.reg_dst = DST_RT; c.wb_sel = WB_ALUOUT; end
      S_JUMP:   begin c.pc_write = 1'b1; c.pc_src = PC_JUMP; end
      S_JAL: begin
        c.pc_write  = 1'b1;
        c.pc_src    = PC_JUMP;
        c.reg_write = 1'b1;
        c.reg_dst   = DST_R31;
        c.wb_sel    = WB_PC;
      end
      S_HALT:   c.halted = 1'b1;
      default:  c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_fsm_if.sv
// Memory handshake between the controller (master) and the memory (slave).
interface multicycle_ctrl_fsm_if;
  logic mem_req;
  logic mem_write;
  logic i_or_d;
  logic mem_ready;

  modport master (output mem_req, mem_write, i_or_d, input mem_ready);
  modport slave  (input mem_req, mem_write, i_or_d, output mem_ready);
endinterface

// File: rtl/multicycle_ctrl_fsm_wait_timer.sv
// mc_mem_wait_timer: counts consecutive stalled memory cycles; expired flags
// the stalled cycle that brings the count to 2**WAIT_W-1.
module mc_mem_wait_timer #(
  parameter int WAIT_W = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic stall,
  input  logic clr,
  output logic expired
);

  // Count value held during the last allowed stall (all ones minus one).
  localparam logic [WAIT_W-1:0] FIRE_AT = {{(WAIT_W-1){1'b1}}, 1'b0};

  logic [WAIT_W-1:0] cnt;

  assign expired = stall && (cnt == FIRE_AT);

  // Stall counter, cleared on completion or any state change.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      cnt <= '0;
    else if (clr)   cnt <= '0;
    else if (stall) cnt <= cnt + WAIT_W'(1);
  end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// multicycle_ctrl_fsm: main control FSM of the multicycle MIPS datapath with a
// variable-latency memory handshake, memory timeout, retired-instruction counter
// and sticky HALT.
// Optional feature macro: MC_CTRL_ILLEGAL_TRAP_EN (undecoded opcode traps to HALT
// and sets illegal_instr; when undefined such opcodes retire as NOPs).
module multicycle_ctrl_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int WAIT_W = 8,
  parameter int RET_W  = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [5:0]              opcode,
  multicycle_ctrl_fsm_if.master   mem,
  output logic                    ir_write,
  output logic                    pc_write,
  output logic                    branch,
  output logic                    branch_ne,
  output logic [1:0]              pc_src,
  output logic                    alu_src_a,
  output logic [1:0]              alu_src_b,
  output logic [2:0]              alu_op,
  output logic                    reg_write,
  output logic [1:0]              reg_dst,
  output logic [1:0]              wb_sel,
  output logic                    halted,
  output logic                    bus_err,
  output logic                    illegal_instr,
  output logic [RET_W-1:0]        instr_retired
);

  localparam logic [RET_W-1:0] RET_ONE = RET_W'(1);

  state_t           state, state_n;
  ctrl_t            ctrl_q;
  logic [5:0]       op_q, op_sel;
  logic             bus_err_q;
  logic [RET_W-1:0] retired_q;
  logic             stall, tmr_clr, expired, retire;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  logic             trap, ill_q;
`endif

  // The IR opcode is only trusted in DECODE; later states use the latched copy.
  assign op_sel  = (state == S_DECODE) ? opcode : op_q;
  assign stall   = ctrl_q.mem_req & ~mem.mem_ready;
  assign tmr_clr = mem.mem_ready | (state_n != state);
  assign retire  = (state_n == S_FETCH) && (state != S_FETCH);

  mc_mem_wait_timer #(.WAIT_W(WAIT_W)) u_wait (
    .clk     (clk),
    .reset   (reset),
    .stall   (stall),
    .clr     (tmr_clr),
    .expired (expired)
  );

  // Next-state selection; memory states complete on mem_ready or trap on timeout.
  always_comb begin
    state_n = state;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    trap = 1'b0;
`endif
    case (state)
      S_FETCH: begin
        if (mem.mem_ready) state_n = S_DECODE;
        else if (expired)  state_n = S_HALT;
      end
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW:              state_n = S_MEMADR;
          OP_RTYPE:                  state_n = S_EXEC;
          OP_BEQ:                    state_n = S_BEQ;
          OP_BNE:                    state_n = S_BNE;
          OP_ADDI, OP_ANDI, OP_ORI:  state_n = S_IMMEX;
          OP_J:                      state_n = S_JUMP;
          OP_JAL:                    state_n = S_JAL;
          default: begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
            state_n = S_HALT;
            trap    = 1'b1;
`else
            state_n = S_FETCH;
`endif
          end
        endcase
      end
      S_MEMADR: state_n = (op_q == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD: begin
        if (mem.mem_ready) state_n = S_MEMWB;
        else if (expired)  state_n = S_HALT;
      end
      S_MEMWR: begin
        if (mem.mem_ready) state_n = S_FETCH;
        else if (expired)  state_n = S_HALT;
      end
      S_EXEC:  state_n = S_ALUWB;
      S_IMMEX: state_n = S_IMMWB;
      S_MEMWB, S_ALUWB, S_BEQ, S_BNE, S_IMMWB, S_JUMP, S_JAL: state_n = S_FETCH;
      S_HALT:  state_n = S_HALT;
      default: state_n = S_FETCH;
    endcase
  end

  // State, registered control word, latched opcode, sticky flags and retire count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_FETCH;
      ctrl_q    <= ctrl_of(S_FETCH, 6'h00);
      op_q      <= '0;
      bus_err_q <= 1'b0;
      retired_q <= '0;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
      ill_q     <= 1'b0;
`endif
    end else begin
      state  <= state_n;
      ctrl_q <= ctrl_of(state_n, op_sel);
      if (state == S_DECODE) op_q <= opcode;
      if (expired) bus_err_q <= 1'b1;
      if (retire)  retired_q <= retired_q + RET_ONE;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
      if (trap) ill_q <= 1'b1;
`endif
    end
  end

  // FETCH enables are the only ones that follow mem_ready within the cycle.
  assign ir_write      = (state == S_FETCH) & mem.mem_ready;
  assign pc_write      = ctrl_q.pc_write | ir_write;
  assign mem.mem_req   = ctrl_q.mem_req;
  assign mem.mem_write = ctrl_q.mem_write;
  assign mem.i_or_d    = ctrl_q.i_or_d;
  assign branch        = ctrl_q.branch;
  assign branch_ne     = ctrl_q.branch_ne;
  assign pc_src        = ctrl_q.pc_src;
  assign alu_src_a     = ctrl_q.alu_src_a;
  assign alu_src_b     = ctrl_q.alu_src_b;
  assign alu_op        = ctrl_q.alu_op;
  assign reg_write     = ctrl_q.reg_write;
  assign reg_dst       = ctrl_q.reg_dst;
  assign wb_sel        = ctrl_q.wb_sel;
  assign halted        = ctrl_q.halted;
  assign bus_err       = bus_err_q;
  assign instr_retired = retired_q;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  assign illegal_instr = ill_q;
`else
  assign illegal_instr = 1'b0;
`endif

endmodule
